// File: rtl/hack_pkg.sv
// Shared Hack datapath constants and word type.
package hack_pkg;

    localparam int unsigned HACK_WIDTH = 16;

    typedef logic [HACK_WIDTH-1:0] hack_word_t;

endpackage

// File: rtl/not16_unit_if.sv
// Operand/result bundle for the 16-bit inverter unit.
interface not16_unit_if
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH = HACK_WIDTH
);

    logic [WIDTH-1:0] in;
    logic             en;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             out_valid;

    modport master (
        output in,
        output en,
        input  out,
        input  out_q,
        input  out_valid
    );

    modport slave (
        input  in,
        input  en,
        output out,
        output out_q,
        output out_valid
    );

endinterface

// File: rtl/not16_unit_not1_nand.sv
// Single-bit inverter built from a two-input nand with both inputs tied together.
module not1_nand (
    input  wire i_a,
    output wire o_y
);

    nand u_nand (o_y, i_a, i_a);

endmodule

// File: rtl/not16_unit.sv
// Bitwise inverter: combinational complement plus a registered copy with valid flag.
module not16_unit
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH       = HACK_WIDTH,
    parameter bit          NAND_STRUCT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    not16_unit_if.slave  bus
);

    logic [WIDTH-1:0] w_out;
    logic [WIDTH-1:0] r_out_q;
    logic             r_out_valid;

    if (NAND_STRUCT) begin : g_nand
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            not1_nand u_not (
                .i_a (bus.in[i]),
                .o_y (w_out[i])
            );
        end
    end else begin : g_beh
        assign w_out = ~bus.in;
    end

    // Combinational path is independent of clock, reset and enable.
    assign bus.out = w_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q     <= '0;
            r_out_valid <= 1'b0;
        end else if (bus.en) begin
            r_out_q     <= w_out;
            r_out_valid <= 1'b1;
        end
    end

    assign bus.out_q     = r_out_q;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_not16_unit.sv
// Scoreboard bench for not16_unit: both NAND and behavioural builds against a simple model.
module tb_not16_unit;
    import hack_pkg::*;

    typedef struct packed {
        hack_word_t q;
        logic       v;
    } exp_t;

    logic clk     = 1'b0;
    logic clk_run = 1'b0;
    logic rst_n   = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    exp_t exp_q[$];

    not16_unit_if #(.WIDTH(16)) if_n ();
    not16_unit_if #(.WIDTH(16)) if_b ();

    not16_unit #(.WIDTH(16), .NAND_STRUCT(1'b1)) u_dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_n.slave)
    );

    not16_unit #(.WIDTH(16), .NAND_STRUCT(1'b0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    always #5 clk = clk_run ? ~clk : clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input hack_word_t w, input logic e);
        if_n.in = w;
        if_b.in = w;
        if_n.en = e;
        if_b.en = e;
    endtask

    // Combinational expectation computed arithmetically: complement is all-ones minus value.
    task automatic check_comb(input string name, input hack_word_t w);
        hack_word_t req;
        req = hack_word_t'(16'hFFFF - w);
        check({name, "_nand"}, 32'(if_n.out), 32'(req));
        check({name, "_beh"},  32'(if_b.out), 32'(req));
    endtask

    task automatic check_reg(input string name, input hack_word_t q, input logic v);
        check({name, "_q_nand"}, 32'(if_n.out_q), 32'(q));
        check({name, "_v_nand"}, 32'(if_n.out_valid), 32'(v));
        check({name, "_q_beh"},  32'(if_b.out_q), 32'(q));
        check({name, "_v_beh"},  32'(if_b.out_valid), 32'(v));
    endtask

    // Monitor: each rising edge that had an expectation queued is checked just after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_reg("sb", e.q, e.v);
        end
    end

    hack_word_t model_q;
    logic       model_v;

    initial begin
        hack_word_t w;
        logic       e;
        logic       r;
        model_q = '0;
        model_v = 1'b0;

        // Combinational checks with reset held and no clock.
        drive(16'h0000, 1'b0);
        #10;
        check_comb("comb_zero", 16'h0000);
        check_reg("reset_state", 16'h0000, 1'b0);
        drive(16'hFFFF, 1'b0);
        #10;
        check_comb("comb_ones", 16'hFFFF);
        drive(16'hA5A5, 1'b0);
        #10;
        check_comb("comb_a5a5", 16'hA5A5);
        check({"comb_a5a5_const"}, 32'(if_n.out), 32'h5A5A);
        drive(16'h1234, 1'b0);
        #10;
        check_comb("comb_1234", 16'h1234);
        check({"comb_1234_const"}, 32'(if_b.out), 32'hEDCB);

        // Reset held with clock running and enable high.
        drive(16'h00FF, 1'b1);
        clk_run = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_reg("rst_hold", 16'h0000, 1'b0);
            check({"rst_comb"}, 32'(if_n.out), 32'hFF00);
        end

        // Release reset and load.
        rst_n = 1'b1;
        drive(16'h0F0F, 1'b1);
        exp_q.push_back('{q: 16'hF0F0, v: 1'b1});
        @(negedge clk);
        drive(16'hFFFF, 1'b0);
        exp_q.push_back('{q: 16'hF0F0, v: 1'b1});
        @(negedge clk);
        exp_q.push_back('{q: 16'hF0F0, v: 1'b1});
        @(negedge clk);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_reg("async_rst", 16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Double inversion through the combinational path.
        for (int k = 0; k < 4; k++) begin
            w = hack_word_t'($urandom);
            drive(w, 1'b0);
            #1;
            drive(if_n.out, 1'b0);
            #1;
            check("double_inv", 32'(if_n.out), 32'(w));
        end
        @(negedge clk);

        // Randomized run with occasional async resets.
        for (int k = 0; k < 300; k++) begin
            w = hack_word_t'($urandom);
            e = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 19) == 0);
            rst_n = ~r;
            drive(w, e);
            if (r) begin
                model_q = '0;
                model_v = 1'b0;
            end else if (e) begin
                model_q = hack_word_t'(16'hFFFF - w);
                model_v = 1'b1;
            end
            exp_q.push_back('{q: model_q, v: model_v});
            #1;
            check_comb("rand_comb", w);
            @(negedge clk);
        end
        rst_n = 1'b1;
        drive(16'h0000, 1'b0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
